// File: rtl/ederah_stream_sender.sv
// Serializes an optional NFA segment followed by a query segment into one AXI4-Stream per start request.
// Optional feature macro: EDERAH_NFA_CACHE_EN skips the NFA segment when its hash matches the last one sent.
module ederah_stream_sender #(
  parameter int C_INPUTS_STREAM_TDATA_WIDTH = 512,
  parameter int C_BEAT_CNT_WIDTH            = 16
) (
  input  logic                                     data_clk,
  input  logic                                     data_rst,
  input  logic                                     start,
  input  logic [31:0]                              nfa_hash,
  input  logic [C_BEAT_CNT_WIDTH-1:0]              nfa_beats,
  input  logic [C_BEAT_CNT_WIDTH-1:0]              query_beats,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     error,
  output logic                                     nfa_reloaded,
  input  logic                                     nfa_tvalid,
  output logic                                     nfa_tready,
  input  logic [C_INPUTS_STREAM_TDATA_WIDTH-1:0]   nfa_tdata,
  input  logic                                     qry_tvalid,
  output logic                                     qry_tready,
  input  logic [C_INPUTS_STREAM_TDATA_WIDTH-1:0]   qry_tdata,
  output logic                                     inputs_stream_tvalid,
  input  logic                                     inputs_stream_tready,
  output logic [C_INPUTS_STREAM_TDATA_WIDTH-1:0]   inputs_stream_tdata,
  output logic [C_INPUTS_STREAM_TDATA_WIDTH/8-1:0] inputs_stream_tkeep,
  output logic                                     inputs_stream_tlast
);

  localparam int DW = C_INPUTS_STREAM_TDATA_WIDTH;
  localparam int CW = C_BEAT_CNT_WIDTH;

  typedef enum logic [2:0] {IDLE, SEND_NFA, SEND_QUERY, DRAIN, FINISH} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   nfa_len_q;
  logic [CW-1:0]   qry_len_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;
  logic            reloaded_q;
  logic            nfa_rdy_q;
  logic            qry_rdy_q;

  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;
  logic            out_last_q;
  logic            skid_valid_q;
  logic [DW-1:0]   skid_data_q;
  logic            skid_last_q;

  logic            reload_req;
  logic            reject;
  logic            nfa_acc;
  logic            qry_acc;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic [CW-1:0]   seg_len;
  logic [CW-1:0]   cnt_inc;
  logic            seg_end;
  logic            out_acc;
  logic            out_free;
  logic            skid_valid_d;
  logic            space_next;

`ifdef EDERAH_NFA_CACHE_EN
  logic [31:0]     hash_q;
  logic [31:0]     last_hash_q;
  logic            hash_valid_q;

  assign reload_req = !hash_valid_q || (nfa_hash != last_hash_q);
`else
  logic            unused_hash;

  assign reload_req  = 1'b1;
  assign unused_hash = ^nfa_hash;
`endif

  assign reject   = (query_beats == '0) || (reload_req && (nfa_beats == '0));

  assign nfa_acc  = nfa_tvalid & nfa_rdy_q;
  assign qry_acc  = qry_tvalid & qry_rdy_q;
  assign in_valid = nfa_acc | qry_acc;
  assign in_data  = nfa_acc ? nfa_tdata : qry_tdata;
  assign seg_len  = (state_q == SEND_NFA) ? nfa_len_q : qry_len_q;
  assign cnt_inc  = cnt_q + CW'(1);
  assign seg_end  = (cnt_inc == seg_len);

  // Source ready is registered from the skid occupancy expected next cycle,
  // so it never combinationally depends on the downstream tready.
  assign out_acc      = out_valid_q & inputs_stream_tready;
  assign out_free     = !out_valid_q | out_acc;
  assign skid_valid_d = out_free ? 1'b0 : (skid_valid_q | in_valid);
  assign space_next   = ~skid_valid_d;

  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= skid_data_q;
        out_last_q  <= skid_last_q;
      end else begin
        out_valid_q <= in_valid;
        if (in_valid) begin
          out_data_q <= in_data;
          out_last_q <= seg_end;
        end
      end
      skid_valid_q <= 1'b0;
    end else if (in_valid) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data;
      skid_last_q  <= seg_end;
    end
  end

  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nfa_len_q    <= '0;
      qry_len_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      reloaded_q   <= 1'b0;
      nfa_rdy_q    <= 1'b0;
      qry_rdy_q    <= 1'b0;
`ifdef EDERAH_NFA_CACHE_EN
      hash_q       <= '0;
      last_hash_q  <= '0;
      hash_valid_q <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      nfa_rdy_q <= 1'b0;
      qry_rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            nfa_len_q  <= nfa_beats;
            qry_len_q  <= query_beats;
            cnt_q      <= '0;
            reloaded_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef EDERAH_NFA_CACHE_EN
            hash_q     <= nfa_hash;
`endif
            if (reject) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else if (reload_req) begin
              state_q   <= SEND_NFA;
              nfa_rdy_q <= space_next;
            end else begin
              state_q   <= SEND_QUERY;
              qry_rdy_q <= space_next;
            end
          end
        end
        SEND_NFA: begin
          nfa_rdy_q <= space_next;
          if (nfa_acc) begin
            if (seg_end) begin
              cnt_q      <= '0;
              state_q    <= SEND_QUERY;
              nfa_rdy_q  <= 1'b0;
              qry_rdy_q  <= space_next;
              reloaded_q <= 1'b1;
`ifdef EDERAH_NFA_CACHE_EN
              last_hash_q  <= hash_q;
              hash_valid_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        SEND_QUERY: begin
          qry_rdy_q <= space_next;
          if (qry_acc) begin
            if (seg_end) begin
              cnt_q     <= '0;
              state_q   <= DRAIN;
              qry_rdy_q <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        DRAIN: begin
          if (!out_valid_q && !skid_valid_q) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign error                = error_q;
  assign nfa_reloaded         = reloaded_q;
  assign nfa_tready           = nfa_rdy_q;
  assign qry_tready           = qry_rdy_q;
  assign inputs_stream_tvalid = out_valid_q;
  assign inputs_stream_tdata  = out_data_q;
  assign inputs_stream_tlast  = out_last_q;
  assign inputs_stream_tkeep  = '1;

endmodule
